// File: rtl/rr_arbiter_if.sv
// Request/grant bundle between four requesters and the round-robin arbiter.
interface rr_arbiter_if;
  logic [3:0] req_in;
  logic [3:0] gnt_out;
  logic [1:0] gnt_id_out;
  logic       gnt_valid_out;

  modport master (
    output req_in,
    input  gnt_out,
    input  gnt_id_out,
    input  gnt_valid_out
  );

  modport slave (
    input  req_in,
    output gnt_out,
    output gnt_id_out,
    output gnt_valid_out
  );
endinterface

// File: rtl/rr_arbiter.sv
// Four-way round-robin arbiter with bounded grant tenure and registered outputs.
module rr_arbiter #(
  parameter int unsigned MAX_HOLD = 8
) (
  input logic         clk,
  input logic         rst,
  rr_arbiter_if.slave bus
);

  localparam int unsigned HW = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] MAX_HOLD_C = HW'(MAX_HOLD);
  localparam logic [HW-1:0] ONE_C      = HW'(1);

  typedef enum logic {IDLE, GRANT} state_e;

  state_e        state_q, state_d;
  logic [1:0]    ptr_q, ptr_d;
  logic [1:0]    id_q, id_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic [3:0]    gnt_q, gnt_d;
  logic [1:0]    gnt_id_q, gnt_id_d;
  logic          gnt_valid_q, gnt_valid_d;

  logic [1:0]    search_ptr;
  logic          win_found;
  logic [1:0]    win_idx;

  // Returns {found, index} of the first requester at or after start (mod 4).
  function automatic logic [2:0] find_winner(input logic [3:0] req,
                                             input logic [1:0] start);
    logic       found;
    logic [1:0] idx;
    logic [1:0] cand;
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      cand = start + 2'(i);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
    return {found, idx};
  endfunction

  // A release in GRANT searches from holder+1, which is also the new ptr.
  always_comb begin
    search_ptr             = (state_q == GRANT) ? id_q + 2'd1 : ptr_q;
    {win_found, win_idx}   = find_winner(bus.req_in, search_ptr);

    state_d     = state_q;
    ptr_d       = ptr_q;
    id_d        = id_q;
    hold_cnt_d  = hold_cnt_q;
    gnt_d       = gnt_q;
    gnt_id_d    = gnt_id_q;
    gnt_valid_d = gnt_valid_q;

    case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d     = GRANT;
          id_d        = win_idx;
          hold_cnt_d  = ONE_C;
          gnt_d       = 4'b0001 << win_idx;
          gnt_id_d    = win_idx;
          gnt_valid_d = 1'b1;
        end
      end
      GRANT: begin
        if (bus.req_in[id_q] && (hold_cnt_q < MAX_HOLD_C)) begin
          hold_cnt_d = hold_cnt_q + ONE_C;
        end else begin
          ptr_d = id_q + 2'd1;
          if (win_found) begin
            id_d        = win_idx;
            hold_cnt_d  = ONE_C;
            gnt_d       = 4'b0001 << win_idx;
            gnt_id_d    = win_idx;
            gnt_valid_d = 1'b1;
          end else begin
            state_d     = IDLE;
            hold_cnt_d  = '0;
            gnt_d       = '0;
            gnt_id_d    = '0;
            gnt_valid_d = 1'b0;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      id_q        <= '0;
      hold_cnt_q  <= '0;
      gnt_q       <= '0;
      gnt_id_q    <= '0;
      gnt_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      id_q        <= id_d;
      hold_cnt_q  <= hold_cnt_d;
      gnt_q       <= gnt_d;
      gnt_id_q    <= gnt_id_d;
      gnt_valid_q <= gnt_valid_d;
    end
  end

  assign bus.gnt_out       = gnt_q;
  assign bus.gnt_id_out    = gnt_id_q;
  assign bus.gnt_valid_out = gnt_valid_q;

endmodule
